ghost_mode_ctrl: RTL and testbench



---
 rtl/ghost_mode_ctrl_if.sv | 22 ++
 rtl/ghost_mode_ctrl.sv | 109 ++++++++++
 tb/tb_ghost_mode_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ghost_mode_ctrl_if.sv
// Event inputs and mode outputs of the per-ghost mode controller.
// master drives game events; slave is the controller.
interface ghost_mode_ctrl_if;
  logic       one_hz_enable;
  logic       chase;
  logic       power_pellet;
  logic       ghost_caught;
  logic       at_home;
  logic [1:0] mode;
  logic       reverse;
  logic [3:0] fright_left;
  logic       flash;

  modport master (
    output one_hz_enable, chase, power_pellet, ghost_caught, at_home,
    input  mode, reverse, fright_left, flash
  );
  modport slave (
    input  one_hz_enable, chase, power_pellet, ghost_caught, at_home,
    output mode, reverse, fright_left, flash
  );
endinterface

// File: rtl/ghost_mode_ctrl.sv
// Per-ghost SCATTER/CHASE/FRIGHT/EATEN mode controller with reverse pulse and frightened countdown.
// Define GHOST_FLASH_EN to drive the frightened-ending flash output; otherwise flash is tied low.
module ghost_mode_ctrl #(
  parameter int FRIGHT_SECS = 6,
  parameter int FLASH_SECS  = 2
) (
  input logic              clk,
  input logic              reset,
  ghost_mode_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    SCATTER = 2'b00,
    CHASE   = 2'b01,
    FRIGHT  = 2'b10,
    EATEN   = 2'b11
  } mode_e;

  localparam logic [3:0] FRIGHT_L = 4'(FRIGHT_SECS);

  if (FRIGHT_SECS < 1 || FRIGHT_SECS > 15 || FLASH_SECS > FRIGHT_SECS) begin : g_cfg_err
    $error("ghost_mode_ctrl: illegal FRIGHT_SECS/FLASH_SECS");
  end

  mode_e       mode_q, mode_d;
  logic        chase_q;
  logic        rev_q, rev_d;
  logic [3:0]  left_q, left_d;
  logic        chase_edge;
  mode_e       phase_now, phase_held;

  assign chase_edge = bus.chase != chase_q;
  assign phase_now  = bus.chase ? CHASE : SCATTER;
  // Exits from FRIGHT/EATEN use the phase as last registered, not this cycle's input.
  assign phase_held = chase_q ? CHASE : SCATTER;

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q  <= CHASE;
      chase_q <= 1'b1;
      rev_q   <= 1'b0;
      left_q  <= 4'd0;
    end else begin
      mode_q  <= mode_d;
      chase_q <= bus.chase;
      rev_q   <= rev_d;
      left_q  <= left_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    left_d = left_q;
    rev_d  = 1'b0;
    case (mode_q)
      SCATTER, CHASE: begin
        if (bus.power_pellet) begin
          mode_d = FRIGHT;
          left_d = FRIGHT_L;
          rev_d  = 1'b1;
        end else if (chase_edge) begin
          mode_d = phase_now;
          rev_d  = 1'b1;
        end
      end
      FRIGHT: begin
        if (bus.ghost_caught) begin
          mode_d = EATEN;
          left_d = 4'd0;
        end else if (bus.power_pellet) begin
          left_d = FRIGHT_L;
        end else if (bus.one_hz_enable) begin
          if (left_q <= 4'd1) begin
            mode_d = phase_held;
            left_d = 4'd0;
          end else begin
            left_d = left_q - 4'd1;
          end
        end
      end
      EATEN: begin
        if (bus.at_home) mode_d = phase_held;
      end
      default: mode_d = CHASE;
    endcase
  end

  assign bus.mode        = mode_q;
  assign bus.reverse     = rev_q;
  assign bus.fright_left = left_q;

`ifdef GHOST_FLASH_EN
  localparam logic [3:0] FLASH_L = 4'(FLASH_SECS);
  logic flash_q, flash_d;

  // Odd seconds within the final window light up, giving a 1 s on/off blink.
  assign flash_d = (mode_d == FRIGHT) && (left_d != 4'd0) && (left_d <= FLASH_L) && left_d[0];

  always_ff @(posedge clk) begin
    if (reset) flash_q <= 1'b0;
    else       flash_q <= flash_d;
  end

  assign bus.flash = flash_q;
`else
  assign bus.flash = 1'b0;
`endif

endmodule

// File: tb/tb_ghost_mode_ctrl.sv
// Scoreboard bench for ghost_mode_ctrl: directed game scenarios followed by random event traffic.
module tb_ghost_mode_ctrl;

  localparam int FS  = 6;
  localparam int FLS = 2;

  logic clk = 1'b0;
  logic reset;
  ghost_mode_ctrl_if gi();

  ghost_mode_ctrl #(.FRIGHT_SECS(FS), .FLASH_SECS(FLS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (gi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic       rev;
    logic [3:0] left;
    logic       flash;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference model: game-level view of the ghost (0 scatter, 1 chase, 2 fright, 3 eaten).
  int m_mode, m_left;
  bit m_phase, m_rev;
  bit cur_chase;

  function automatic bit flash_of(int md, int lf);
`ifdef GHOST_FLASH_EN
    return (md == 2) && (lf > 0) && (lf <= FLS) && (lf % 2 == 1);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model(input bit r, ch, pp, gc, hm, tk);
    bit phase_changed;
    if (r) begin
      m_mode = 1; m_left = 0; m_phase = 1; m_rev = 0;
      return;
    end
    phase_changed = (ch != m_phase);
    m_rev = 0;
    if (m_mode == 0 || m_mode == 1) begin
      if (pp) begin m_mode = 2; m_left = FS; m_rev = 1; end
      else if (phase_changed) begin m_mode = ch ? 1 : 0; m_rev = 1; end
    end else if (m_mode == 2) begin
      if (gc) begin m_mode = 3; m_left = 0; end
      else if (pp) m_left = FS;
      else if (tk) begin
        m_left = m_left - 1;
        if (m_left == 0) m_mode = m_phase ? 1 : 0;
      end
    end else if (hm) begin
      m_mode = m_phase ? 1 : 0;
    end
    m_phase = ch;
  endtask

  task automatic step(input bit r, ch, pp, gc, hm, tk);
    exp_t e;
    @(negedge clk);
    reset            = r;
    gi.chase         = ch;
    gi.power_pellet  = pp;
    gi.ghost_caught  = gc;
    gi.at_home       = hm;
    gi.one_hz_enable = tk;
    cur_chase        = ch;
    model(r, ch, pp, gc, hm, tk);
    e.mode  = 2'(m_mode);
    e.rev   = m_rev;
    e.left  = 4'(m_left);
    e.flash = flash_of(m_mode, m_left);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, cur_chase, 0, 0, 0, 0);
  endtask

  task automatic tick();
    step(0, cur_chase, 0, 0, 0, 1);
    idle(2);
  endtask

  // Monitor: every cycle the DUT presents its registered outputs; compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 1) begin
        bad++; total++;
        $display("FAIL scoreboard_backlog cyc=%0d depth=%0d want<=1", cyc, exp_q.size());
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (gi.mode !== e.mode || gi.reverse !== e.rev || gi.fright_left !== e.left || gi.flash !== e.flash) begin
          bad++;
          $display("FAIL outputs cyc=%0d got mode=%0d rev=%0d left=%0d flash=%0d want mode=%0d rev=%0d left=%0d flash=%0d",
                   cyc, gi.mode, gi.reverse, gi.fright_left, gi.flash, e.mode, e.rev, e.left, e.flash);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    gi.chase = 1'b1; gi.power_pellet = 1'b0; gi.ghost_caught = 1'b0;
    gi.at_home = 1'b0; gi.one_hz_enable = 1'b0;
    cur_chase = 1'b1;
    m_mode = 1; m_left = 0; m_phase = 1; m_rev = 0;

    // Reset, then chase falls: one reverse, SCATTER.
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0);
    idle(7);
    step(0, 0, 0, 0, 0, 0);
    idle(4);

    // Back to chase, then a full frightened period.
    step(0, 1, 0, 0, 0, 0);
    idle(2);
    step(0, 1, 1, 0, 0, 0);
    idle(2);
    for (int i = 0; i < FS; i++) tick();

    // Reload at fright_left=3 with a coincident tick; chase toggles inside FRIGHT.
    step(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    step(0, 1, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    idle(2);
    for (int i = 0; i < FS; i++) tick();

    // Caught + pellet together, then ignored events in EATEN, then home with scatter.
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    tick();
    step(0, 1, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    idle(2);
    step(0, 0, 0, 0, 1, 0);
    idle(2);

    // Pellet coincident with a chase edge in SCATTER.
    step(0, 1, 1, 0, 0, 0);
    idle(3);

    // Reset in FRIGHT with fright_left=4, and in EATEN.
    step(0, 1, 1, 0, 0, 0);
    tick(); tick();
    step(1, 1, 0, 0, 0, 0);
    idle(2);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0);
    idle(2);
    step(1, 1, 0, 0, 0, 0);
    idle(2);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      bit r, ch, pp, gc, hm, tk;
      r  = ($urandom_range(0, 299) == 0);
      ch = ($urandom_range(0, 24) == 0) ? ~cur_chase : cur_chase;
      pp = ($urandom_range(0, 29) == 0);
      gc = ($urandom_range(0, 19) == 0);
      hm = ($urandom_range(0, 14) == 0);
      tk = ($urandom_range(0, 3) == 0);
      step(r, ch, pp, gc, hm, tk);
    end

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      bad++; total++;
      $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
